rob_commit: RTL and testbench

- Reorder buffer and in-order commit unit for the dual-issue pipeline.
- Allocates tags (ROB tail pointers) to up to two instructions per cycle at dispatch.
- Accepts out-of-order results from the two ALU lanes and the load/store lane, keyed by tag.
- Retires up to two results per cycle in program order. Its commit outputs drive the execute stage's fwd_data/fwd_reg/fwd_data_WB forwarding inputs and the register-file write ports.

---
 rtl/rob_commit_pkg.sv | 21 ++
 rtl/rob_entry_array.sv | 120 ++++++++++++
 rtl/rob_commit.sv | 164 ++++++++++++++++
 tb/tb_rob_commit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// Shared ROB definitions: default geometry, tag width seen by the execute
// stage, and the per-entry record returned by the entry array read ports.
package rob_commit_pkg;

  localparam int ROB_DEPTH  = 64;
  localparam int ROB_PTR_W  = 6;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_REG_W  = 6;

  // Width of the tags carried on the completion buses.
  localparam int ROB_TAG_W  = ROB_PTR_W;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  do_wb;
    logic [ROB_REG_W-1:0]  dest;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage: two allocate ports, three prioritised completion ports
// (cmp1 > cmp2 > cmpls on a shared tag), two commit-clear ports and two read
// ports at head / head+1. All writes hold while FREEZE is high.
module rob_entry_array
  import rob_commit_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int PTR_W = ROB_PTR_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FREEZE,
  input  logic                  alloc_we1,
  input  logic [PTR_W-1:0]      alloc_idx1,
  input  logic [ROB_REG_W-1:0]  alloc_dest1,
  input  logic                  alloc_do_wb1,
  input  logic                  alloc_we2,
  input  logic [PTR_W-1:0]      alloc_idx2,
  input  logic [ROB_REG_W-1:0]  alloc_dest2,
  input  logic                  alloc_do_wb2,
  input  logic                  cmp1_valid,
  input  logic [PTR_W-1:0]      cmp1_tag,
  input  logic [ROB_DATA_W-1:0] cmp1_data,
  input  logic                  cmp2_valid,
  input  logic [PTR_W-1:0]      cmp2_tag,
  input  logic [ROB_DATA_W-1:0] cmp2_data,
  input  logic                  cmpls_valid,
  input  logic [PTR_W-1:0]      cmpls_tag,
  input  logic [ROB_DATA_W-1:0] cmpls_data,
  input  logic                  clr1,
  input  logic [PTR_W-1:0]      clr_idx1,
  input  logic                  clr2,
  input  logic [PTR_W-1:0]      clr_idx2,
  input  logic [PTR_W-1:0]      rd_idx1,
  input  logic [PTR_W-1:0]      rd_idx2,
  output rob_entry_t            rd_entry1,
  output rob_entry_t            rd_entry2,
  output logic                  ls_accept,
  output logic [ROB_REG_W-1:0]  ls_dest,
  output logic                  ls_do_wb
);

  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      done;
  logic                  do_wb_q [DEPTH];
  logic [ROB_REG_W-1:0]  dest_q  [DEPTH];
  logic [ROB_DATA_W-1:0] data_q  [DEPTH];

  logic acc1, acc2, accls;
  logic dup12, dup1ls, dup2ls;

  // A completion lands only on a live, still-pending entry; a lower-priority
  // lane loses to any valid higher lane carrying the same tag.
  always_comb begin
    dup12  = cmp1_valid && (cmp1_tag == cmp2_tag);
    dup1ls = cmp1_valid && (cmp1_tag == cmpls_tag);
    dup2ls = cmp2_valid && (cmp2_tag == cmpls_tag);
    acc1   = cmp1_valid  && busy[cmp1_tag]  && !done[cmp1_tag];
    acc2   = cmp2_valid  && busy[cmp2_tag]  && !done[cmp2_tag]  && !dup12;
    accls  = cmpls_valid && busy[cmpls_tag] && !done[cmpls_tag] && !dup1ls && !dup2ls;
  end

  // Entry status bits; allocation and commit never target the same entry
  // because alloc_ready keeps two free slots ahead of the tail.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy <= '0;
      done <= '0;
    end else if (!FREEZE) begin
      if (clr1) busy[clr_idx1] <= 1'b0;
      if (clr2) busy[clr_idx2] <= 1'b0;
      if (alloc_we1) begin
        busy[alloc_idx1] <= 1'b1;
        done[alloc_idx1] <= 1'b0;
      end
      if (alloc_we2) begin
        busy[alloc_idx2] <= 1'b1;
        done[alloc_idx2] <= 1'b0;
      end
      if (acc1)  done[cmp1_tag]  <= 1'b1;
      if (acc2)  done[cmp2_tag]  <= 1'b1;
      if (accls) done[cmpls_tag] <= 1'b1;
    end
  end

  // Entry payload; meaningless while busy is clear, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (!FREEZE) begin
      if (alloc_we1) begin
        dest_q[alloc_idx1]  <= alloc_dest1;
        do_wb_q[alloc_idx1] <= alloc_do_wb1;
      end
      if (alloc_we2) begin
        dest_q[alloc_idx2]  <= alloc_dest2;
        do_wb_q[alloc_idx2] <= alloc_do_wb2;
      end
      if (acc1)  data_q[cmp1_tag]  <= cmp1_data;
      if (acc2)  data_q[cmp2_tag]  <= cmp2_data;
      if (accls) data_q[cmpls_tag] <= cmpls_data;
    end
  end

  // Commit read ports and the LS-lane entry lookup.
  always_comb begin
    rd_entry1.busy  = busy[rd_idx1];
    rd_entry1.done  = done[rd_idx1];
    rd_entry1.do_wb = do_wb_q[rd_idx1];
    rd_entry1.dest  = dest_q[rd_idx1];
    rd_entry1.data  = data_q[rd_idx1];
    rd_entry2.busy  = busy[rd_idx2];
    rd_entry2.done  = done[rd_idx2];
    rd_entry2.do_wb = do_wb_q[rd_idx2];
    rd_entry2.dest  = dest_q[rd_idx2];
    rd_entry2.data  = data_q[rd_idx2];
    ls_accept       = accls;
    ls_dest         = dest_q[cmpls_tag];
    ls_do_wb        = do_wb_q[cmpls_tag];
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with dual dispatch allocation, three out-of-order result
// lanes and in-order dual commit into the forwarding / register-file ports.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int PTR_W  = ROB_PTR_W,
  parameter int DATA_W = ROB_DATA_W,
  parameter int REG_W  = ROB_REG_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FREEZE,
  input  logic              alloc_valid1,
  input  logic              alloc_valid2,
  input  logic [REG_W-1:0]  alloc_dest1,
  input  logic [REG_W-1:0]  alloc_dest2,
  input  logic              alloc_do_wb1,
  input  logic              alloc_do_wb2,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  tail_pointer1,
  output logic [PTR_W-1:0]  tail_pointer2,
  input  logic              cmp1_valid,
  input  logic [PTR_W-1:0]  cmp1_tag,
  input  logic [DATA_W-1:0] cmp1_data,
  input  logic              cmp2_valid,
  input  logic [PTR_W-1:0]  cmp2_tag,
  input  logic [DATA_W-1:0] cmp2_data,
  input  logic              cmpls_valid,
  input  logic [PTR_W-1:0]  cmpls_tag,
  input  logic [DATA_W-1:0] cmpls_data,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
  output logic [REG_W-1:0]  fwd_reg_1,
  output logic [REG_W-1:0]  fwd_reg_2,
  output logic              fwd_data_1_WB,
  output logic              fwd_data_2_WB,
  output logic [DATA_W-1:0] LS_fwd_data,
  output logic [REG_W-1:0]  LS_fwd_reg,
  output logic              LS_fwd_data_WB,
  output logic              rob_empty
);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] head_plus1;
  logic [PTR_W-1:0] tail_plus1;

  logic       alloc_go, alloc_two;
  logic       commit1, commit2;
  logic [1:0] n_alloc, n_commit;

  rob_entry_t      entry1, entry2;
  logic            ls_accept;
  logic [REG_W-1:0] ls_dest;
  logic            ls_do_wb;

  // Allocation is gated on the pre-edge count only; commit is decided from
  // the pre-edge entry state, so a same-cycle completion cannot bypass.
  always_comb begin
    head_plus1    = head + PTR_W'(1);
    tail_plus1    = tail + PTR_W'(1);
    alloc_ready   = (count <= (PTR_W+1)'(DEPTH - 2));
    rob_empty     = (count == '0);
    tail_pointer1 = tail;
    tail_pointer2 = tail_plus1;
    alloc_go      = alloc_valid1 && alloc_ready;
    alloc_two     = alloc_go && alloc_valid2;
    commit1       = entry1.busy && entry1.done;
    commit2       = commit1 && entry2.busy && entry2.done;
    n_alloc       = {alloc_two, alloc_go && !alloc_two};
    n_commit      = {commit2, commit1 && !commit2};
  end

  rob_entry_array #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_entries (
    .CLK          (CLK),
    .RESET        (RESET),
    .FREEZE       (FREEZE),
    .alloc_we1    (alloc_go),
    .alloc_idx1   (tail),
    .alloc_dest1  (alloc_dest1),
    .alloc_do_wb1 (alloc_do_wb1),
    .alloc_we2    (alloc_two),
    .alloc_idx2   (tail_plus1),
    .alloc_dest2  (alloc_dest2),
    .alloc_do_wb2 (alloc_do_wb2),
    .cmp1_valid   (cmp1_valid),
    .cmp1_tag     (cmp1_tag),
    .cmp1_data    (cmp1_data),
    .cmp2_valid   (cmp2_valid),
    .cmp2_tag     (cmp2_tag),
    .cmp2_data    (cmp2_data),
    .cmpls_valid  (cmpls_valid),
    .cmpls_tag    (cmpls_tag),
    .cmpls_data   (cmpls_data),
    .clr1         (commit1),
    .clr_idx1     (head),
    .clr2         (commit2),
    .clr_idx2     (head_plus1),
    .rd_idx1      (head),
    .rd_idx2      (head_plus1),
    .rd_entry1    (entry1),
    .rd_entry2    (entry2),
    .ls_accept    (ls_accept),
    .ls_dest      (ls_dest),
    .ls_do_wb     (ls_do_wb)
  );

  // Head/tail advance by 0..2 and wrap through the natural pointer width.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (!FREEZE) begin
      head  <= head + PTR_W'(n_commit);
      tail  <= tail + PTR_W'(n_alloc);
      count <= count + (PTR_W+1)'(n_alloc) - (PTR_W+1)'(n_commit);
    end
  end

  // Registered commit ports; WB strobes drop in any cycle without a commit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fwd_data_1    <= '0;
      fwd_data_2    <= '0;
      fwd_reg_1     <= '0;
      fwd_reg_2     <= '0;
      fwd_data_1_WB <= 1'b0;
      fwd_data_2_WB <= 1'b0;
    end else if (!FREEZE) begin
      fwd_data_1_WB <= commit1 && entry1.do_wb;
      fwd_data_2_WB <= commit2 && entry2.do_wb;
      if (commit1) begin
        fwd_data_1 <= entry1.data;
        fwd_reg_1  <= entry1.dest;
      end
      if (commit2) begin
        fwd_data_2 <= entry2.data;
        fwd_reg_2  <= entry2.dest;
      end
    end
  end

  // Early forward of an accepted load/store result, one cycle after it arrives.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      LS_fwd_data    <= '0;
      LS_fwd_reg     <= '0;
      LS_fwd_data_WB <= 1'b0;
    end else if (!FREEZE) begin
      LS_fwd_data_WB <= ls_accept && ls_do_wb;
      if (ls_accept) begin
        LS_fwd_data <= cmpls_data;
        LS_fwd_reg  <= ls_dest;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: expected commits and LS forwards are queued
// when stimulus is issued and popped by a monitor whenever a WB strobe shows.
module tb_rob_commit;

  logic        CLK = 1'b0;
  logic        RESET, FREEZE;
  logic        alloc_valid1, alloc_valid2;
  logic [5:0]  alloc_dest1, alloc_dest2;
  logic        alloc_do_wb1, alloc_do_wb2;
  logic        alloc_ready;
  logic [5:0]  tail_pointer1, tail_pointer2;
  logic        cmp1_valid, cmp2_valid, cmpls_valid;
  logic [5:0]  cmp1_tag, cmp2_tag, cmpls_tag;
  logic [31:0] cmp1_data, cmp2_data, cmpls_data;
  logic [31:0] fwd_data_1, fwd_data_2, LS_fwd_data;
  logic [5:0]  fwd_reg_1, fwd_reg_2, LS_fwd_reg;
  logic        fwd_data_1_WB, fwd_data_2_WB, LS_fwd_data_WB;
  logic        rob_empty;

  typedef struct {
    logic [5:0]  rg;
    logic [31:0] data;
  } exp_t;

  exp_t cq[$];
  exp_t lq[$];
  int   checks = 0;
  int   errors = 0;
  logic fresh  = 1'b0;
  logic [5:0] m_tail;
  logic [5:0] t0, t1, t2;

  always #5 CLK = ~CLK;

  rob_commit dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .FREEZE         (FREEZE),
    .alloc_valid1   (alloc_valid1),
    .alloc_valid2   (alloc_valid2),
    .alloc_dest1    (alloc_dest1),
    .alloc_dest2    (alloc_dest2),
    .alloc_do_wb1   (alloc_do_wb1),
    .alloc_do_wb2   (alloc_do_wb2),
    .alloc_ready    (alloc_ready),
    .tail_pointer1  (tail_pointer1),
    .tail_pointer2  (tail_pointer2),
    .cmp1_valid     (cmp1_valid),
    .cmp1_tag       (cmp1_tag),
    .cmp1_data      (cmp1_data),
    .cmp2_valid     (cmp2_valid),
    .cmp2_tag       (cmp2_tag),
    .cmp2_data      (cmp2_data),
    .cmpls_valid    (cmpls_valid),
    .cmpls_tag      (cmpls_tag),
    .cmpls_data     (cmpls_data),
    .fwd_data_1     (fwd_data_1),
    .fwd_data_2     (fwd_data_2),
    .fwd_reg_1      (fwd_reg_1),
    .fwd_reg_2      (fwd_reg_2),
    .fwd_data_1_WB  (fwd_data_1_WB),
    .fwd_data_2_WB  (fwd_data_2_WB),
    .LS_fwd_data    (LS_fwd_data),
    .LS_fwd_reg     (LS_fwd_reg),
    .LS_fwd_data_WB (LS_fwd_data_WB),
    .rob_empty      (rob_empty)
  );

  function automatic logic [5:0] dest_of(input logic [5:0] t);
    return t ^ 6'h2A;
  endfunction

  function automatic logic [31:0] data_of(input logic [5:0] t, input logic [7:0] salt);
    return {8'hC0, salt, 10'b0, t};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_commit(input string name, input logic [5:0] rg, input logic [31:0] d);
    exp_t e;
    checks++;
    if (cq.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected commit reg %0d data %0h, none expected", name, rg, d);
    end else begin
      e = cq.pop_front();
      if (rg !== e.rg || d !== e.data) begin
        errors++;
        $display("FAIL %s: got reg %0d data %0h expected reg %0d data %0h", name, rg, d, e.rg, e.data);
      end
    end
  endtask

  // An output is a fresh presentation only if the last edge was neither frozen nor in reset.
  always @(posedge CLK) fresh <= RESET && !FREEZE;

  // Monitor: pop and compare each visible commit / LS forward in order.
  always @(negedge CLK) begin
    if (fresh) begin
      if (fwd_data_1_WB) pop_commit("commit_slot1", fwd_reg_1, fwd_data_1);
      if (fwd_data_2_WB) pop_commit("commit_slot2", fwd_reg_2, fwd_data_2);
      if (LS_fwd_data_WB) begin
        checks++;
        if (lq.size() == 0) begin
          errors++;
          $display("FAIL ls_fwd: unexpected reg %0d data %0h", LS_fwd_reg, LS_fwd_data);
        end else begin
          exp_t e;
          e = lq.pop_front();
          if (LS_fwd_reg !== e.rg || LS_fwd_data !== e.data) begin
            errors++;
            $display("FAIL ls_fwd: got reg %0d data %0h expected reg %0d data %0h",
                     LS_fwd_reg, LS_fwd_data, e.rg, e.data);
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    alloc_valid1 = 0; alloc_valid2 = 0;
    alloc_dest1 = 0; alloc_dest2 = 0; alloc_do_wb1 = 0; alloc_do_wb2 = 0;
    cmp1_valid = 0; cmp2_valid = 0; cmpls_valid = 0;
    cmp1_tag = 0; cmp2_tag = 0; cmpls_tag = 0;
    cmp1_data = 0; cmp2_data = 0; cmpls_data = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    clear_inputs();
  endtask

  task automatic alloc1(input logic wb);
    alloc_valid1 = 1; alloc_dest1 = dest_of(m_tail); alloc_do_wb1 = wb;
    step();
    m_tail = m_tail + 6'd1;
  endtask

  task automatic alloc2(input logic wb1, input logic wb2);
    alloc_valid1 = 1; alloc_dest1 = dest_of(m_tail);         alloc_do_wb1 = wb1;
    alloc_valid2 = 1; alloc_dest2 = dest_of(m_tail + 6'd1);  alloc_do_wb2 = wb2;
    step();
    m_tail = m_tail + 6'd2;
  endtask

  task automatic push_c(input logic [5:0] t, input logic [31:0] d);
    exp_t e;
    e.rg = dest_of(t); e.data = d;
    cq.push_back(e);
  endtask

  initial begin
    clear_inputs();
    RESET = 0; FREEZE = 0; m_tail = 0;
    repeat (3) @(posedge CLK);
    #1;
    // reset state
    check("rst_empty", 32'(rob_empty), 1);
    check("rst_ready", 32'(alloc_ready), 1);
    check("rst_tp1", 32'(tail_pointer1), 0);
    check("rst_tp2", 32'(tail_pointer2), 1);
    check("rst_wb1", 32'(fwd_data_1_WB), 0);
    check("rst_wb2", 32'(fwd_data_2_WB), 0);
    check("rst_lswb", 32'(LS_fwd_data_WB), 0);
    RESET = 1;
    step();

    // out-of-order completion, in-order dual commit (dests 5,6 as in the plan)
    alloc_valid1 = 1; alloc_dest1 = 6'd5; alloc_do_wb1 = 1;
    alloc_valid2 = 1; alloc_dest2 = 6'd6; alloc_do_wb2 = 1;
    step();
    m_tail = 6'd2;
    check("tp1_after_alloc", 32'(tail_pointer1), 2);
    check("empty_after_alloc", 32'(rob_empty), 0);
    cmp2_valid = 1; cmp2_tag = 6'd1; cmp2_data = 32'hBEEF;
    step();
    step(); step();
    check("no_commit_wb1", 32'(fwd_data_1_WB), 0);
    check("no_commit_wb2", 32'(fwd_data_2_WB), 0);
    begin
      exp_t e;
      e.rg = 6'd5; e.data = 32'h1234; cq.push_back(e);
      e.rg = 6'd6; e.data = 32'hBEEF; cq.push_back(e);
    end
    cmp1_valid = 1; cmp1_tag = 6'd0; cmp1_data = 32'h1234;
    step();
    check("no_bypass_wb1", 32'(fwd_data_1_WB), 0);
    step();
    check("pair_wb1", 32'(fwd_data_1_WB), 1);
    check("pair_wb2", 32'(fwd_data_2_WB), 1);
    check("pair_reg1", 32'(fwd_reg_1), 5);
    check("pair_data2", fwd_data_2, 32'hBEEF);
    step();
    check("pair_empty", 32'(rob_empty), 1);

    // fill to 63 entries
    for (int i = 0; i < 31; i++) alloc2(1, 1);
    alloc1(1);
    check("full_ready", 32'(alloc_ready), 0);
    check("full_tp1", 32'(tail_pointer1), 32'(m_tail));
    alloc_valid1 = 1; alloc_dest1 = 6'h3F; alloc_do_wb1 = 1;
    step();
    check("full_ignored_tp1", 32'(tail_pointer1), 32'(m_tail));
    cmp1_valid = 1; cmp1_tag = 6'd2; cmp1_data = data_of(6'd2, 8'h01); push_c(6'd2, data_of(6'd2, 8'h01));
    cmp2_valid = 1; cmp2_tag = 6'd3; cmp2_data = data_of(6'd3, 8'h01); push_c(6'd3, data_of(6'd3, 8'h01));
    step();
    check("full_ready_before_commit", 32'(alloc_ready), 0);
    step();
    check("ready_after_commit", 32'(alloc_ready), 1);
    for (int k = 0; k < 61; k += 2) begin
      logic [5:0] t;
      t = 6'(4 + k);
      cmp1_valid = 1; cmp1_tag = t; cmp1_data = data_of(t, 8'h02); push_c(t, data_of(t, 8'h02));
      if (k + 1 < 61) begin
        cmp2_valid = 1; cmp2_tag = t + 6'd1; cmp2_data = data_of(t + 6'd1, 8'h02);
        push_c(t + 6'd1, data_of(t + 6'd1, 8'h02));
      end
      step();
    end
    repeat (3) step();
    check("drain_empty", 32'(rob_empty), 1);

    // wrap: 70 single alloc/complete/commit, every third via the LS lane
    for (int i = 0; i < 70; i++) begin
      logic [5:0] t;
      t = m_tail;
      alloc1(1);
      check("wrap_tp1", 32'(tail_pointer1), 32'(m_tail));
      if (i % 3 == 0) begin
        exp_t e;
        cmpls_valid = 1; cmpls_tag = t; cmpls_data = data_of(t, 8'h03);
        e.rg = dest_of(t); e.data = data_of(t, 8'h03); lq.push_back(e);
      end else begin
        cmp1_valid = 1; cmp1_tag = t; cmp1_data = data_of(t, 8'h03);
      end
      push_c(t, data_of(t, 8'h03));
      step();
    end
    repeat (3) step();
    check("wrap_empty", 32'(rob_empty), 1);

    // duplicate tag priority and late completions after done
    t0 = m_tail; t1 = m_tail + 6'd1;
    alloc2(1, 1);
    cmp1_valid = 1;  cmp1_tag = t1;  cmp1_data = 32'hAAAA;
    cmpls_valid = 1; cmpls_tag = t1; cmpls_data = 32'h5555;
    step();
    check("dup_ls_wb", 32'(LS_fwd_data_WB), 0);
    cmpls_valid = 1; cmpls_tag = t1; cmpls_data = 32'h7777;
    step();
    check("late_ls_wb", 32'(LS_fwd_data_WB), 0);
    cmp2_valid = 1; cmp2_tag = t1; cmp2_data = 32'h9999;
    step();
    cmp1_valid = 1; cmp1_tag = t0; cmp1_data = data_of(t0, 8'h04);
    push_c(t0, data_of(t0, 8'h04));
    push_c(t1, 32'hAAAA);
    step();
    step();
    check("dup_data2", fwd_data_2, 32'hAAAA);
    check("dup_wb2", 32'(fwd_data_2_WB), 1);

    // store entry retires without WB
    t0 = m_tail; t1 = m_tail + 6'd1;
    alloc2(0, 1);
    cmp1_valid = 1; cmp1_tag = t0; cmp1_data = data_of(t0, 8'h05);
    cmp2_valid = 1; cmp2_tag = t1; cmp2_data = data_of(t1, 8'h05);
    push_c(t1, data_of(t1, 8'h05));
    step();
    step();
    check("store_wb1", 32'(fwd_data_1_WB), 0);
    check("store_next_wb2", 32'(fwd_data_2_WB), 1);
    check("store_empty", 32'(rob_empty), 1);

    // FREEZE holds a pending commit, drops allocations, then holds outputs
    t2 = m_tail;
    alloc1(1);
    cmp1_valid = 1; cmp1_tag = t2; cmp1_data = data_of(t2, 8'h06);
    push_c(t2, data_of(t2, 8'h06));
    step();
    FREEZE = 1;
    step(); step();
    check("frz_wb1", 32'(fwd_data_1_WB), 0);
    check("frz_not_empty", 32'(rob_empty), 0);
    alloc_valid1 = 1; alloc_dest1 = 6'd9; alloc_do_wb1 = 1;
    step();
    check("frz_tp1", 32'(tail_pointer1), 32'(m_tail));
    FREEZE = 0;
    step();
    check("unfrz_wb1", 32'(fwd_data_1_WB), 1);
    check("unfrz_reg1", 32'(fwd_reg_1), 32'(dest_of(t2)));
    FREEZE = 1;
    step(); step();
    check("frz_hold_wb1", 32'(fwd_data_1_WB), 1);
    check("frz_hold_data1", fwd_data_1, data_of(t2, 8'h06));
    FREEZE = 0;
    step();
    check("after_frz_wb1", 32'(fwd_data_1_WB), 0);
    check("after_frz_empty", 32'(rob_empty), 1);

    // reset mid-operation discards entries
    alloc2(1, 1);
    cmp1_valid = 1; cmp1_tag = m_tail - 6'd2; cmp1_data = 32'hDEAD;
    step();
    RESET = 0;
    #2;
    check("midrst_empty", 32'(rob_empty), 1);
    check("midrst_tp1", 32'(tail_pointer1), 0);
    step(); step();
    RESET = 1;
    step(); step();
    check("midrst_wb1", 32'(fwd_data_1_WB), 0);
    check("midrst_still_empty", 32'(rob_empty), 1);

    check("commit_queue_drained", 32'(cq.size()), 0);
    check("ls_queue_drained", 32'(lq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
